fb_port_arbiter: RTL

- Shares the single-port 12-bit frame-buffer RAM (800x600 = 480000 words) between three requesters: the display scan-out, the pixel painter, and an internal clear-screen sequencer.
- Display reads are real-time and always win. Painter writes use valid/ready flow control. The clear engine fills the whole buffer with one colour, using only cycles the display leaves free.
- Sits between the VGA timing/scan block and the frame-buffer RAM, clocked on pclk.

---
 rtl/fb_port_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: shares one single-port RAM between display reads,
// painter writes and a full-buffer clear sequencer, with fixed-priority grant.
module fb_port_arbiter #(
    parameter int AW    = 19,
    parameter int DW    = 12,
    parameter int DEPTH = 480000,
    parameter int SW    = 16
) (
    input  logic          pclk,
    input  logic          rstn,
    // display read port
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    // painter write port
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    // clear engine control
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    // status
    output logic          err_oob,
    output logic [SW-1:0] stall_cnt,
    // RAM port
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   C_DEPTH     = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_LAST      = AW'(DEPTH - 1);
    localparam logic [SW-1:0] C_STALL_MAX = '1;

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_clr_ptr, w_clr_ptr_next;
    logic [DW-1:0] r_clr_color, w_clr_color_next;
    logic          r_clr_done, w_clr_done_next;
    logic          r_rd_valid;
    logic          r_err_oob;
    logic [SW-1:0] r_stall_cnt;

    logic          w_gnt_rd;
    logic          w_gnt_clr;
    logic          w_gnt_wr;
    logic          w_wr_inrange;

    // Ready depends only on rd_req and state; grants are additionally masked
    // by reset so no RAM write can leak out while rstn is low.
    assign wr_ready     = !rd_req && (r_state == ST_IDLE);
    assign w_gnt_rd     = rstn && rd_req;
    assign w_gnt_clr    = rstn && !rd_req && (r_state == ST_CLEAR);
    assign w_gnt_wr     = rstn && wr_valid && wr_ready;
    assign w_wr_inrange = ({1'b0, wr_addr} < C_DEPTH);

    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        if (w_gnt_rd) begin
            ram_addr = rd_addr;
        end else if (w_gnt_clr) begin
            ram_addr  = r_clr_ptr;
            ram_we    = 1'b1;
            ram_wdata = r_clr_color;
        end else if (w_gnt_wr) begin
            // Out-of-range writes still complete the handshake but never hit RAM.
            ram_addr  = wr_addr;
            ram_we    = w_wr_inrange;
            ram_wdata = wr_data;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_clr_ptr_next   = r_clr_ptr;
        w_clr_color_next = r_clr_color;
        w_clr_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_next     = ST_CLEAR;
                    w_clr_ptr_next   = '0;
                    w_clr_color_next = clr_color;
                end
            end
            ST_CLEAR: begin
                if (!rd_req) begin
                    if (r_clr_ptr == C_LAST) begin
                        w_state_next    = ST_IDLE;
                        w_clr_ptr_next  = '0;
                        w_clr_done_next = 1'b1;
                    end else begin
                        w_clr_ptr_next = r_clr_ptr + AW'(1);
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_clr_ptr   <= '0;
            r_clr_color <= '0;
            r_clr_done  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_err_oob   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_clr_ptr   <= w_clr_ptr_next;
            r_clr_color <= w_clr_color_next;
            r_clr_done  <= w_clr_done_next;
            r_rd_valid  <= rd_req;
            if (w_gnt_wr && !w_wr_inrange) begin
                r_err_oob <= 1'b1;
            end
            if (wr_valid && !wr_ready && (r_stall_cnt != C_STALL_MAX)) begin
                r_stall_cnt <= r_stall_cnt + SW'(1);
            end
        end
    end

    assign rd_data   = ram_rdata;
    assign rd_valid  = r_rd_valid;
    assign clr_busy  = (r_state == ST_CLEAR);
    assign clr_done  = r_clr_done;
    assign err_oob   = r_err_oob;
    assign stall_cnt = r_stall_cnt;

endmodule
